// File: rtl/branch_unit_pkg.sv
// Shared definitions for the ID-stage branch unit: branch codes, BTB geometry,
// 2-bit predictor counter encoding and the table entry layout.
package branch_unit_pkg;

  localparam int unsigned ENTRIES = 16;
  localparam int unsigned IDX_W   = $clog2(ENTRIES);
  localparam int unsigned TAG_W   = 30 - IDX_W;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_BEQ  = 3'd1;
  localparam logic [2:0] BR_BNE  = 3'd2;
  localparam logic [2:0] BR_BGTZ = 3'd3;
  localparam logic [2:0] BR_BLTZ = 3'd4;
  localparam logic [2:0] BR_BGEZ = 3'd5;
  localparam logic [2:0] BR_BLEZ = 3'd6;

  localparam logic [1:0] CTR_SNT = 2'd0;
  localparam logic [1:0] CTR_WNT = 2'd1;
  localparam logic [1:0] CTR_WT  = 2'd2;
  localparam logic [1:0] CTR_ST  = 2'd3;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
    logic [1:0]       ctr;
  } btb_entry_t;

  // Saturating 2-bit counter step toward the resolved direction.
  function automatic logic [1:0] ctr_next(input logic [1:0] ctr, input logic taken);
    logic [1:0] res;
    res = ctr;
    if (taken && ctr != CTR_ST) res = ctr + 2'd1;
    else if (!taken && ctr != CTR_SNT) res = ctr - 2'd1;
    return res;
  endfunction

endpackage

// File: rtl/branch_unit_btb_table.sv
// Direct-mapped branch target buffer: combinational lookup on the fetch word
// address, registered update from the resolving branch.
module btb_table
  import branch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [29:0] lookup_addr,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_en,
  input  logic [29:0] upd_addr,
  input  logic        upd_taken,
  input  logic [31:0] upd_target
);

  btb_entry_t entries [ENTRIES];

  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic [IDX_W-1:0] up_idx;
  logic [TAG_W-1:0] up_tag;
  btb_entry_t       lk_ent;
  btb_entry_t       up_ent;
  logic             lk_hit;
  logic             up_hit;

  assign lk_idx = lookup_addr[IDX_W-1:0];
  assign lk_tag = lookup_addr[29:IDX_W];
  assign up_idx = upd_addr[IDX_W-1:0];
  assign up_tag = upd_addr[29:IDX_W];

  assign lk_ent = entries[lk_idx];
  assign up_ent = entries[up_idx];
  assign lk_hit = lk_ent.valid && (lk_ent.tag == lk_tag);
  assign up_hit = up_ent.valid && (up_ent.tag == up_tag);

  // Lookup reads the pre-edge contents, so a same-cycle update is seen next cycle.
  assign pred_taken  = lk_hit && lk_ent.ctr[1];
  assign pred_target = lk_hit ? lk_ent.target : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(ENTRIES); i++) begin
        entries[i] <= '{valid: 1'b0, tag: '0, target: 32'd0, ctr: CTR_WNT};
      end
    end else if (upd_en) begin
      if (up_hit) begin
        entries[up_idx].ctr    <= ctr_next(up_ent.ctr, upd_taken);
        entries[up_idx].target <= upd_target;
      end else if (upd_taken) begin
        entries[up_idx] <= '{valid: 1'b1, tag: up_tag, target: upd_target, ctr: CTR_WT};
      end
    end
  end

endmodule

// File: rtl/branch_unit.sv
// ID-stage branch resolution: condition decode, target adder, PC redirect and
// IF/ID flush, resolution statistics, and the BTB that feeds IF predictions.
module branch_unit
  import branch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        id_valid,
  input  logic        id_stall,
  input  logic [31:0] id_pc,
  input  logic [2:0]  id_br_type,
  input  logic [15:0] id_imm,
  input  logic        id_pred_taken,
  input  logic        zero,
  input  logic        gz,
  input  logic        lz,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        flush_ifid,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
);

  logic        is_br;
  logic        taken;
  logic        resolve;
  logic        mispredict;
  logic [31:0] offset;
  logic [31:0] fallthrough;
  logic [31:0] target;
  logic        if_pc_unused;

  // Fetch PCs are word aligned; the byte offset never reaches the table.
  assign if_pc_unused = ^if_pc[1:0];

  // Condition decode; unused code 7 falls into the not-a-branch default.
  always_comb begin
    is_br = 1'b1;
    taken = 1'b0;
    case (id_br_type)
      BR_BEQ:  taken = zero;
      BR_BNE:  taken = !zero;
      BR_BGTZ: taken = gz;
      BR_BLTZ: taken = lz;
      BR_BGEZ: taken = !lz;
      BR_BLEZ: taken = !gz;
      default: is_br = 1'b0;
    endcase
  end

  assign offset      = {{14{id_imm[15]}}, id_imm, 2'b00};
  assign fallthrough = id_pc + 32'd4;
  assign target      = fallthrough + offset;

  assign resolve     = id_valid && !id_stall && is_br;
  assign mispredict  = resolve && (taken != id_pred_taken);
  assign redirect    = mispredict;
  assign flush_ifid  = mispredict;
  assign redirect_pc = (mispredict && taken) ? target : fallthrough;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count      <= 32'd0;
      mispred_count <= 32'd0;
    end else begin
      if (resolve)    br_count      <= br_count + 32'd1;
      if (mispredict) mispred_count <= mispred_count + 32'd1;
    end
  end

  btb_table u_btb (
    .clk         (clk),
    .rst_n       (rst_n),
    .lookup_addr (if_pc[31:2]),
    .pred_taken  (pred_taken),
    .pred_target (pred_target),
    .upd_en      (resolve),
    .upd_addr    (id_pc[31:2]),
    .upd_taken   (taken),
    .upd_target  (target)
  );

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: stimulus pushes hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_branch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        id_valid;
  logic        id_stall;
  logic [31:0] id_pc;
  logic [2:0]  id_br_type;
  logic [15:0] id_imm;
  logic        id_pred_taken;
  logic        zero, gz, lz;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        flush_ifid;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [127:0] name;
    logic         pt;
    logic [31:0]  ptgt;
    logic         red;
    logic [31:0]  rpc;
    logic [31:0]  brc;
    logic [31:0]  mis;
  } exp_t;

  exp_t q[$];

  always #5 clk = ~clk;

  branch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .if_pc         (if_pc),
    .pred_taken    (pred_taken),
    .pred_target   (pred_target),
    .id_valid      (id_valid),
    .id_stall      (id_stall),
    .id_pc         (id_pc),
    .id_br_type    (id_br_type),
    .id_imm        (id_imm),
    .id_pred_taken (id_pred_taken),
    .zero          (zero),
    .gz            (gz),
    .lz            (lz),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .flush_ifid    (flush_ifid),
    .br_count      (br_count),
    .mispred_count (mispred_count)
  );

  function automatic void cmp(input logic [127:0] name, input string field,
                              input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %0s.%0s: got 0x%08h expected 0x%08h", name, field, act, exp);
    end
  endfunction

  // Monitor: every cycle's outputs are sampled mid-cycle against queued expectations.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      cmp(e.name, "pred_taken",    32'(pred_taken),  32'(e.pt));
      cmp(e.name, "pred_target",   pred_target,      e.ptgt);
      cmp(e.name, "redirect",      32'(redirect),    32'(e.red));
      cmp(e.name, "flush_ifid",    32'(flush_ifid),  32'(e.red));
      cmp(e.name, "redirect_pc",   redirect_pc,      e.rpc);
      cmp(e.name, "br_count",      br_count,         e.brc);
      cmp(e.name, "mispred_count", mispred_count,    e.mis);
    end
  end

  task automatic drive(input logic v, input logic st, input logic [31:0] pc,
                       input logic [2:0] bt, input logic [15:0] imm, input logic pt,
                       input logic z, input logic g, input logic l, input logic [31:0] ipc);
    id_valid = v; id_stall = st; id_pc = pc; id_br_type = bt; id_imm = imm;
    id_pred_taken = pt; zero = z; gz = g; lz = l; if_pc = ipc;
  endtask

  task automatic idle(input logic [31:0] ipc);
    drive(1'b0, 1'b0, 32'h0040_0000, 3'd0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, ipc);
  endtask

  task automatic expect_out(input logic [127:0] name, input logic pt, input logic [31:0] ptgt,
                            input logic red, input logic [31:0] rpc,
                            input logic [31:0] brc, input logic [31:0] mis);
    exp_t e;
    e.name = name; e.pt = pt; e.ptgt = ptgt; e.red = red; e.rpc = rpc;
    e.brc = brc; e.mis = mis;
    q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    idle(32'h0040_0000);
    tick(); tick();
    rst_n = 1'b1;

    // Reset state
    idle(32'h0040_0000);
    expect_out("reset", 0, 32'h0, 0, 32'h0040_0004, 0, 0);
    tick();

    // Cold taken BEQ: mispredict, same-cycle lookup still misses
    drive(1, 0, 32'h0040_0010, 3'd1, 16'h0004, 0, 1, 0, 0, 32'h0040_0010);
    expect_out("cold_beq", 0, 32'h0, 1, 32'h0040_0024, 0, 0);
    tick();
    idle(32'h0040_0010);
    expect_out("cold_lookup", 1, 32'h0040_0024, 0, 32'h0040_0004, 1, 1);
    tick();

    // Hysteresis: two more taken -> ctr 3
    drive(1, 0, 32'h0040_0010, 3'd1, 16'h0004, 1, 1, 0, 0, 32'h0040_0010);
    expect_out("taken2", 1, 32'h0040_0024, 0, 32'h0040_0014, 1, 1);
    tick();
    drive(1, 0, 32'h0040_0010, 3'd1, 16'h0004, 1, 1, 0, 0, 32'h0040_0010);
    expect_out("taken3", 1, 32'h0040_0024, 0, 32'h0040_0014, 2, 1);
    tick();
    drive(1, 0, 32'h0040_0010, 3'd1, 16'h0004, 1, 0, 0, 0, 32'h0040_0010);
    expect_out("nt1", 1, 32'h0040_0024, 1, 32'h0040_0014, 3, 1);
    tick();
    idle(32'h0040_0010);
    expect_out("ctr2_pred", 1, 32'h0040_0024, 0, 32'h0040_0004, 4, 2);
    tick();
    drive(1, 0, 32'h0040_0010, 3'd1, 16'h0004, 1, 0, 0, 0, 32'h0040_0010);
    expect_out("nt2", 1, 32'h0040_0024, 1, 32'h0040_0014, 4, 2);
    tick();
    idle(32'h0040_0010);
    expect_out("ctr1_pred", 0, 32'h0040_0024, 0, 32'h0040_0004, 5, 3);
    tick();

    // Backward BLEZ, correctly predicted taken
    drive(1, 0, 32'h0040_0100, 3'd6, 16'hFFFF, 1, 0, 0, 0, 32'h0040_0100);
    expect_out("blez_back", 0, 32'h0, 0, 32'h0040_0104, 5, 3);
    tick();
    idle(32'h0040_0100);
    expect_out("blez_lookup", 1, 32'h0040_0100, 0, 32'h0040_0004, 6, 3);
    tick();

    // Stalled taken BNE at an aliasing index must not touch the table or counts
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 32'h0040_0200, 3'd2, 16'h0008, 0, 0, 0, 0, 32'h0040_0100);
      expect_out("stall", 1, 32'h0040_0100, 0, 32'h0040_0204, 6, 3);
      tick();
    end
    drive(1, 0, 32'h0040_0200, 3'd2, 16'h0008, 0, 0, 0, 0, 32'h0040_0100);
    expect_out("stall_drop", 1, 32'h0040_0100, 1, 32'h0040_0224, 6, 3);
    tick();
    idle(32'h0040_0100);
    expect_out("evicted", 0, 32'h0, 0, 32'h0040_0004, 7, 4);
    tick();
    idle(32'h0040_0200);
    expect_out("bne_lookup", 1, 32'h0040_0224, 0, 32'h0040_0004, 7, 4);
    tick();

    // Aliasing at index 4: 0x50 replaces 0x10
    drive(1, 0, 32'h0040_0050, 3'd1, 16'h0010, 0, 1, 0, 0, 32'h0040_0010);
    expect_out("alias_beq", 0, 32'h0040_0024, 1, 32'h0040_0094, 7, 4);
    tick();
    idle(32'h0040_0010);
    expect_out("alias_old", 0, 32'h0, 0, 32'h0040_0004, 8, 5);
    tick();
    idle(32'h0040_0050);
    expect_out("alias_new", 1, 32'h0040_0094, 0, 32'h0040_0004, 8, 5);
    tick();

    // Remaining condition codes and the unused code 7
    drive(1, 0, 32'h0040_0300, 3'd3, 16'h0002, 0, 0, 1, 0, 32'h0040_0050);
    expect_out("bgtz", 1, 32'h0040_0094, 1, 32'h0040_030C, 8, 5);
    tick();
    drive(1, 0, 32'h0040_0300, 3'd4, 16'h0002, 0, 0, 0, 0, 32'h0040_0050);
    expect_out("bltz_nt", 1, 32'h0040_0094, 0, 32'h0040_0304, 9, 6);
    tick();
    drive(1, 0, 32'h0040_0300, 3'd5, 16'h0002, 1, 0, 0, 1, 32'h0040_0050);
    expect_out("bgez_nt", 1, 32'h0040_0094, 1, 32'h0040_0304, 10, 6);
    tick();
    drive(1, 0, 32'h0040_0300, 3'd7, 16'h0002, 1, 1, 0, 0, 32'h0040_0050);
    expect_out("code7", 1, 32'h0040_0094, 0, 32'h0040_0304, 11, 7);
    tick();
    idle(32'h0040_0300);
    expect_out("ctr0_pred", 0, 32'h0040_030C, 0, 32'h0040_0004, 11, 7);
    tick();

    // Reset mid-operation clears state at once but not the combinational redirect
    drive(1, 0, 32'h0040_0010, 3'd1, 16'h0004, 0, 1, 0, 0, 32'h0040_0050);
    rst_n = 1'b0;
    expect_out("mid_reset", 0, 32'h0, 1, 32'h0040_0024, 0, 0);
    tick();
    idle(32'h0040_0000);
    rst_n = 1'b1;
    tick();

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: got %0d expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
